duty_ramp: RTL and testbench
============================

Name: duty_ramp

Overview:
Soft-start duty generator that sits directly upstream of the PWM core and drives its duty input.
- Ramps duty from its current value toward a programmed target by a fixed step.
- Takes one step every N PWM overflow events, using the PWM ovf_trigger output as its time base.
- Clamps the target to the active period, reports ramp status, and pulses done when the target is reached.

Parameters:
- W, 32: width of duty, target, step and period.
- PRE_W, 16: width of the overflow prescaler.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous reset, active-low (reset==0 resets all state).
- enable  in  1  ramp enable; low forces the idle state.
- period  in  W  current PWM period; the target is clamped to this value.
- target  in  W  requested final duty.
- step  in  W  duty increment/decrement per tick; 0 means jump to target.
- prescale  in  PRE_W  number of ovf_trigger pulses per tick, minus 1.
- ovf_trigger  in  1  one-cycle overflow pulse from the PWM core.
- duty  out  W  duty value presented to the PWM core; registered.
- busy  out  1  high while in RAMP.
- at_target  out  1  high while in HOLD.
- done  out  1  one-cycle pulse on the RAMP->HOLD transition.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, duty=0, prescale counter=0, busy=0, at_target=0, done=0.
- Effective target: tgt_eff = (target > period) ? period : target. It is evaluated combinationally every cycle.
- Tick generation:
  - The prescale counter increments on each ovf_trigger pulse while in RAMP or HOLD.
  - When counter==prescale and ovf_trigger=1, tick=1 and the counter returns to 0. prescale=0 gives one tick per overflow.
  - The counter is cleared in IDLE.
- State IDLE:
  - Holds duty=0.
  - Moves to RAMP on the first cycle with enable=1.
- State RAMP:
  - On a tick with duty<tgt_eff: duty <= min(duty+step, tgt_eff).
  - On a tick with duty>tgt_eff: duty <= max(duty-step, tgt_eff).
  - Add/subtract is computed in W+1 bits. Overflow saturates at tgt_eff; underflow saturates at tgt_eff, so duty is never below 0.
  - step==0: duty <= tgt_eff on the next tick.
  - When the registered duty equals tgt_eff, the next cycle enters HOLD and done=1 for exactly that one cycle.
  - If enable=1 and tgt_eff already equals duty, the block goes RAMP->HOLD in one cycle and done still pulses.
- State HOLD:
  - duty tracks nothing; it is held.
  - If tgt_eff != duty (target or period changed), go to RAMP on the next cycle. The prescale counter is not reset.
- enable=0 in any state: next cycle state=IDLE and duty=0 (without the optional feature).
- Simultaneous events: a tick and a target change in the same cycle use the new tgt_eff for that step.
- Latency:
  - duty changes 1 clk after the ovf_trigger pulse that produced the tick.
  - The PWM core latches duty at its next period wrap, so each step takes effect one PWM period later.
- Outputs: busy = (state==RAMP); at_target = (state==HOLD). Both are registered and decoded from state.

Optional Feature:
Macro: DUTY_RAMP_SOFTSTOP_EN.
- Defined: enable falling while in RAMP or HOLD enters a RAMP_DOWN state.
  - Each tick lowers duty by step, saturating at 0 (step==0 means duty=0 on the next tick).
  - When duty reaches 0 the block enters IDLE and done pulses.
  - enable rising during RAMP_DOWN returns to RAMP from the current duty; duty is not reset.
  - busy=1 during RAMP_DOWN.
- Undefined: enable low forces IDLE and duty=0 on the next cycle; no RAMP_DOWN state exists.

Decomposition:
- Package duty_ramp_pkg:
  - state enum: IDLE, RAMP, HOLD, RAMP_DOWN (RAMP_DOWN used only with the macro).
  - defaults for W and PRE_W.
  - a saturating add/sub function pair on W+1 bits.
- One sub-module, ovf_prescaler:
  - inputs: clk, reset, clr, ovf_trigger, prescale.
  - output: tick.
  - It is reusable for ADC trigger decimation.

Test Plan:
- Basic ramp: enable=1, period=1000, target=500, step=100, prescale=0, ovf every 20 clk -> duty 100,200,300,400,500, each 1 clk after ovf; done pulses once; at_target=1.
- Saturating last step: target=450, step=100 -> duty sequence ends 400,450; no 500 ever appears.
- Clamp to period, then ramp down: period=300, target=1000, step=200 -> duty 200,300, then HOLD. Next, target=100 -> busy=1, duty 100 on the next tick, then HOLD.
- Prescaler and jump: prescale=3, step=0, target=700 -> duty jumps to 700 only on the 4th ovf pulse; pulses 1-3 leave duty=0.
- Async reset mid-ramp: assert reset=0 between clock edges while duty=300 -> duty=0, busy=0 immediately without waiting for a clk edge; after release, IDLE until enable is seen.
- Softstop (macro on): HOLD at duty=500, step=250, enable->0 -> duty 250, then 0, then IDLE with done pulse. Macro off: duty=0 one clk after enable falls.

Source files
------------

// File: rtl/duty_ramp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : duty_ramp_pkg
// Brief    : Shared types, width defaults and saturating helpers for the
//            soft-start duty generator.
// Revision : 1.0  initial release
// ============================================================================
package duty_ramp_pkg;

  // Default widths of duty/target/step/period and of the overflow prescaler
  localparam int DEF_W     = 32;
  localparam int DEF_PRE_W = 16;

  // Widest datapath the helpers support; callers zero-extend into it, so the
  // extra carry/borrow bit makes every add/sub effectively W+1 bits wide.
  localparam int DR_MAX_W  = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP      = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_e;

  // a + b, clamped so the result never exceeds lim
  function automatic logic [DR_MAX_W-1:0] sat_add(input logic [DR_MAX_W-1:0] a,
                                                  input logic [DR_MAX_W-1:0] b,
                                                  input logic [DR_MAX_W-1:0] lim);
    logic [DR_MAX_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) return lim;
    return sum[DR_MAX_W-1:0];
  endfunction

  // a - b, clamped so the result never drops below lim (borrow also clamps)
  function automatic logic [DR_MAX_W-1:0] sat_sub(input logic [DR_MAX_W-1:0] a,
                                                  input logic [DR_MAX_W-1:0] b,
                                                  input logic [DR_MAX_W-1:0] lim);
    logic [DR_MAX_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[DR_MAX_W] || (diff[DR_MAX_W-1:0] < lim)) return lim;
    return diff[DR_MAX_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ovf_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : ovf_prescaler
// Brief    : Divides a stream of one-cycle overflow pulses by (prescale+1)
//            and emits a one-cycle tick. Also usable for ADC trigger
//            decimation.
// Revision : 1.0  initial release
// ============================================================================
module ovf_prescaler #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             ovf_trigger,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q;
  logic [PRE_W-1:0] cnt_d;

  // '>=' rather than '==' so lowering prescale below the running count
  // fires on the next pulse instead of waiting for a full counter wrap.
  assign tick = ~clr & ovf_trigger & (cnt_q >= prescale);

  // Next count: cleared on clr or tick, advanced on every other overflow
  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (ovf_trigger) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Overflow counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/duty_ramp.sv
`default_nettype none
// ============================================================================
// Module   : duty_ramp
// Brief    : Soft-start duty generator feeding the PWM core. Steps duty
//            toward a period-clamped target once every (prescale+1) PWM
//            overflows, and reports busy / at_target / done.
//            Optional macro DUTY_RAMP_SOFTSTOP_EN: dropping enable ramps duty
//            down to 0 (RAMP_DOWN) instead of forcing it to 0 at once.
// Revision : 1.0  initial release
// ============================================================================
module duty_ramp
  import duty_ramp_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [W-1:0]     period,
  input  logic [W-1:0]     target,
  input  logic [W-1:0]     step,
  input  logic [PRE_W-1:0] prescale,
  input  logic             ovf_trigger,
  output logic [W-1:0]     duty,
  output logic             busy,
  output logic             at_target,
  output logic             done
);

  state_e       state_q, state_d;
  logic [W-1:0] duty_q, duty_d;
  logic         busy_q, busy_d;
  logic         at_tgt_q, at_tgt_d;
  logic         done_q, done_d;

  logic [W-1:0] tgt_eff;
  logic [W-1:0] duty_up;
  logic [W-1:0] duty_dn;
  logic         tick;

  // Target can never exceed the active PWM period
  assign tgt_eff = (target > period) ? period : target;

  // Candidate steps toward tgt_eff, saturating at tgt_eff in either direction
  assign duty_up = W'(sat_add(DR_MAX_W'(duty_q), DR_MAX_W'(step), DR_MAX_W'(tgt_eff)));
  assign duty_dn = W'(sat_sub(DR_MAX_W'(duty_q), DR_MAX_W'(step), DR_MAX_W'(tgt_eff)));

  // Counter only runs while ramping or holding; IDLE keeps it at zero
  ovf_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk         (clk),
    .reset       (reset),
    .clr         (state_q == IDLE),
    .ovf_trigger (ovf_trigger),
    .prescale    (prescale),
    .tick        (tick)
  );

  // Next-state, next-duty and registered-output decode
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        duty_d = '0;
        if (enable) state_d = RAMP;
      end

      RAMP, HOLD: begin
        if (!enable) begin
`ifdef DUTY_RAMP_SOFTSTOP_EN
          state_d = RAMP_DOWN;
`else
          state_d = IDLE;
          duty_d  = '0;
`endif
        end else if (state_q == HOLD) begin
          if (duty_q != tgt_eff) state_d = RAMP;
        end else if (duty_q == tgt_eff) begin
          state_d = HOLD;
          done_d  = 1'b1;
        end else if (tick) begin
          if (step == '0)             duty_d = tgt_eff;
          else if (duty_q < tgt_eff)  duty_d = duty_up;
          else                        duty_d = duty_dn;
        end
      end

`ifdef DUTY_RAMP_SOFTSTOP_EN
      RAMP_DOWN: begin
        if (enable) begin
          // Resume from wherever the ramp-down has got to
          state_d = RAMP;
        end else if (duty_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tick) begin
          if (step == '0) duty_d = '0;
          else            duty_d = W'(sat_sub(DR_MAX_W'(duty_q), DR_MAX_W'(step), '0));
        end
      end
`endif

      default: begin
        state_d = IDLE;
        duty_d  = '0;
      end
    endcase

`ifdef DUTY_RAMP_SOFTSTOP_EN
    busy_d   = (state_d == RAMP) || (state_d == RAMP_DOWN);
`else
    busy_d   = (state_d == RAMP);
`endif
    at_tgt_d = (state_d == HOLD);
  end

  // State, duty and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      busy_q   <= 1'b0;
      at_tgt_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      busy_q   <= busy_d;
      at_tgt_q <= at_tgt_d;
      done_q   <= done_d;
    end
  end

  assign duty      = duty_q;
  assign busy      = busy_q;
  assign at_target = at_tgt_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_duty_ramp
// Brief    : Self-checking bench for duty_ramp. Expected duty values are
//            queued as stimulus is applied and popped whenever duty changes.
// Revision : 1.0  initial release
// ============================================================================
module tb_duty_ramp;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] period;
  logic [31:0] target;
  logic [31:0] step;
  logic [15:0] prescale;
  logic        ovf_trigger;
  logic [31:0] duty;
  logic        busy;
  logic        at_target;
  logic        done;

  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  logic [31:0] prev_duty = '0;
  logic [31:0] sb[$];

  duty_ramp u_dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .period      (period),
    .target      (target),
    .step        (step),
    .prescale    (prescale),
    .ovf_trigger (ovf_trigger),
    .duty        (duty),
    .busy        (busy),
    .at_target   (at_target),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every change of duty must match the next queued value
  always @(negedge clk) begin
    if (duty !== prev_duty) begin
      if (sb.size() == 0) chk("sb_unexpected", duty, prev_duty);
      else                chk("sb_duty", duty, sb.pop_front());
    end
    if (done === 1'b1) done_cnt++;
    prev_duty = duty;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One overflow pulse, then the rest of a 20-clk PWM period
  task automatic ovf_pulse();
    ovf_trigger = 1'b1;
    wait_clk(1);
    ovf_trigger = 1'b0;
    wait_clk(19);
  endtask

  // Drop enable long enough to reach IDLE, then re-enable
  task automatic restart();
    enable = 1'b0;
    wait_clk(2);
    enable = 1'b1;
    wait_clk(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; ovf_trigger = 1'b0;
    period = 32'd1000; target = 32'd500; step = 32'd100; prescale = 16'd0;
    wait_clk(3);
    chk("rst_duty", duty, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_at_target", {31'd0, at_target}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    wait_clk(2);

    // Basic ramp 0 -> 500 in steps of 100
    for (int i = 1; i <= 5; i++) sb.push_back(32'(i * 100));
    enable = 1'b1;
    wait_clk(2);
    chk("basic_busy", {31'd0, busy}, 32'd1);
    ovf_trigger = 1'b1;
    chk("lat_before", duty, 32'd0);
    wait_clk(1);
    ovf_trigger = 1'b0;
    chk("lat_after", duty, 32'd100);
    wait_clk(19);
    repeat (4) ovf_pulse();
    exp_done++;
    chk("basic_at_target", {31'd0, at_target}, 32'd1);
    chk("basic_busy_off", {31'd0, busy}, 32'd0);
    chk("basic_done_cnt", 32'(done_cnt), 32'(exp_done));

    // Saturating last step: 400 -> 450
    sb.push_back(32'd0);
    target = 32'd450;
    restart();
    sb.push_back(32'd100); sb.push_back(32'd200); sb.push_back(32'd300);
    sb.push_back(32'd400); sb.push_back(32'd450);
    repeat (5) ovf_pulse();
    exp_done++;
    chk("sat_duty", duty, 32'd450);
    chk("sat_at_target", {31'd0, at_target}, 32'd1);

    // Clamp to period, then ramp down toward a lower target
    sb.push_back(32'd0);
    period = 32'd300; target = 32'd1000; step = 32'd200;
    restart();
    sb.push_back(32'd200); sb.push_back(32'd300);
    repeat (2) ovf_pulse();
    exp_done++;
    chk("clamp_duty", duty, 32'd300);
    chk("clamp_at_target", {31'd0, at_target}, 32'd1);
    target = 32'd100;
    wait_clk(2);
    chk("down_busy", {31'd0, busy}, 32'd1);
    sb.push_back(32'd100);
    ovf_pulse();
    exp_done++;
    chk("down_at_target", {31'd0, at_target}, 32'd1);
    chk("clamp_done_cnt", 32'(done_cnt), 32'(exp_done));

    // Prescaler = 3 with step 0: jump on the 4th overflow only
    sb.push_back(32'd0);
    period = 32'd1000; target = 32'd700; step = 32'd0; prescale = 16'd3;
    restart();
    for (int i = 1; i <= 3; i++) begin
      ovf_pulse();
      chk("pre_hold", duty, 32'd0);
    end
    sb.push_back(32'd700);
    ovf_pulse();
    exp_done++;
    chk("pre_jump", duty, 32'd700);
    chk("pre_done_cnt", 32'(done_cnt), 32'(exp_done));

    // Asynchronous reset in the middle of a ramp
    sb.push_back(32'd0);
    target = 32'd500; step = 32'd100; prescale = 16'd0;
    restart();
    sb.push_back(32'd100); sb.push_back(32'd200); sb.push_back(32'd300);
    repeat (3) ovf_pulse();
    @(posedge clk);
    #3;
    sb.push_back(32'd0);
    reset = 1'b0;
    #1;
    chk("arst_duty", duty, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    enable = 1'b0;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(3);
    ovf_pulse();
    chk("idle_duty", duty, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_at_target", {31'd0, at_target}, 32'd0);
    enable = 1'b1;
    wait_clk(2);
    chk("reen_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 5; i++) sb.push_back(32'(i * 100));
    repeat (5) ovf_pulse();
    exp_done++;
    chk("hold500_at_target", {31'd0, at_target}, 32'd1);

    // Enable falling while holding at 500
    step = 32'd250;
`ifdef DUTY_RAMP_SOFTSTOP_EN
    sb.push_back(32'd250); sb.push_back(32'd0);
    enable = 1'b0;
    wait_clk(2);
    chk("soft_busy", {31'd0, busy}, 32'd1);
    ovf_pulse();
    chk("soft_250", duty, 32'd250);
    ovf_pulse();
    exp_done++;
    chk("soft_zero", duty, 32'd0);
    chk("soft_busy_off", {31'd0, busy}, 32'd0);
`else
    sb.push_back(32'd0);
    enable = 1'b0;
    wait_clk(1);
    chk("stop_duty", duty, 32'd0);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    wait_clk(2);
`endif
    chk("stop_at_target", {31'd0, at_target}, 32'd0);
    chk("final_done_cnt", 32'(done_cnt), 32'(exp_done));
    wait_clk(2);
    chk("sb_leftover", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
